// File: rtl/alu_issue_unit.sv
// Decode/issue front end for control_alu: one MIPS word per 3 cycles, wb_valid in the 2nd cycle after accept.
// Backpressure: instr_ready is high only in IDLE; the source holds instr_valid/instr until accepted.
module alu_issue_unit #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  input  logic [31:0]       instr,
  output logic              instr_ready,
  output logic [5:0]        alu_opcode,
  output logic [5:0]        alu_funct,
  output logic [DATA_W-1:0] alu_A,
  output logic [DATA_W-1:0] alu_B,
  input  logic [DATA_W-1:0] alu_res,
  input  logic              alu_zero,
  output logic              wb_valid,
  output logic [4:0]        wb_reg,
  output logic [DATA_W-1:0] wb_data,
  output logic              zero_flag,
  output logic              illegal,
  input  logic [4:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WB    = 2'd2
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] rf [32];
  logic [4:0]        dest_q;
  logic              do_wb_q;
  logic              zero_q;

  logic [5:0]        op_f, fn_f;
  logic [4:0]        rs_f, rt_f, rd_f;
  logic [15:0]       imm_f;
  logic [DATA_W-1:0] rs_val, rt_val;

  logic [5:0]        d_op, d_fn;
  logic [DATA_W-1:0] d_a, d_b;
  logic [4:0]        d_dest;
  logic              d_wb, d_ill;
  logic              accept;

  assign op_f  = instr[31:26];
  assign rs_f  = instr[25:21];
  assign rt_f  = instr[20:16];
  assign rd_f  = instr[15:11];
  assign imm_f = instr[15:0];
  assign fn_f  = instr[5:0];

  // R0 is never written, so a plain array read already returns 0 for it.
  assign rs_val   = rf[rs_f];
  assign rt_val   = rf[rt_f];
  assign dbg_data = rf[dbg_addr];

  assign instr_ready = (state == IDLE);
  assign accept      = instr_valid && instr_ready;

  always_comb begin
    d_op   = 6'h00;
    d_fn   = 6'h00;
    d_a    = '0;
    d_b    = '0;
    d_dest = 5'd0;
    d_wb   = 1'b0;
    d_ill  = 1'b0;
    case (op_f)
      6'h00: begin
        d_fn   = fn_f;
        d_a    = rs_val;
        d_b    = rt_val;
        d_dest = rd_f;
        case (fn_f)
          6'h20, 6'h22, 6'h24, 6'h25, 6'h18, 6'h1A: d_wb = 1'b1;
          6'h00:                                    d_wb = 1'b0;
          default:                                  d_ill = 1'b1;
        endcase
      end
      6'h08: begin
        d_fn   = 6'h20;
        d_a    = rs_val;
        d_b    = {{(DATA_W-16){imm_f[15]}}, imm_f};
        d_dest = rt_f;
        d_wb   = 1'b1;
      end
      6'h0F: begin
        d_op   = 6'h0F;
        d_b    = {{(DATA_W-16){1'b0}}, imm_f};
        d_dest = rt_f;
        d_wb   = 1'b1;
      end
      default: d_ill = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      alu_opcode <= '0;
      alu_funct  <= '0;
      alu_A      <= '0;
      alu_B      <= '0;
      wb_valid   <= 1'b0;
      wb_reg     <= '0;
      wb_data    <= '0;
      zero_flag  <= 1'b0;
      illegal    <= 1'b0;
      dest_q     <= '0;
      do_wb_q    <= 1'b0;
      zero_q     <= 1'b0;
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          illegal <= 1'b0;
          if (accept) begin
            state      <= ISSUE;
            alu_opcode <= d_op;
            alu_funct  <= d_fn;
            alu_A      <= d_a;
            alu_B      <= d_b;
            dest_q     <= d_dest;
            do_wb_q    <= d_wb;
            illegal    <= d_ill;
          end
        end
        ISSUE: begin
          illegal  <= 1'b0;
          wb_valid <= do_wb_q;
          if (do_wb_q) begin
            wb_reg  <= dest_q;
            wb_data <= alu_res;
            zero_q  <= alu_zero;
          end
          state <= WB;
        end
        WB: begin
          wb_valid <= 1'b0;
          if (wb_valid) begin
            zero_flag <= zero_q;
            if (wb_reg != 5'd0) rf[wb_reg] <= wb_data;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed + random bench for alu_issue_unit with an in-bench ALU stub and architectural register model.
module tb_alu_issue_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic [5:0]  alu_opcode, alu_funct;
  logic [31:0] alu_A, alu_B, alu_res;
  logic        alu_zero;
  logic        wb_valid;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        zero_flag, illegal;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] m_rf [32];
  logic        m_zero;

  always #5 clk = ~clk;

  alu_issue_unit #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
    .alu_opcode(alu_opcode), .alu_funct(alu_funct), .alu_A(alu_A), .alu_B(alu_B),
    .alu_res(alu_res), .alu_zero(alu_zero),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
    .zero_flag(zero_flag), .illegal(illegal),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  function automatic logic [31:0] alu_fn(input logic [5:0] op, input logic [5:0] fn,
                                         input logic [31:0] a, input logic [31:0] b);
    if (op == 6'h0F) return b << 16;
    case (fn)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h18:   return a * b;
      6'h1A:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: return 32'h0;
    endcase
  endfunction

  // Stand-in for the combinational control_alu.
  always_comb begin
    alu_res  = alu_fn(alu_opcode, alu_funct, alu_A, alu_B);
    alu_zero = (alu_res == 32'h0);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drive one instruction (instr_valid stays high afterwards) and check it end to end.
  task automatic issue(input logic [31:0] ins, input bit back_to_back);
    logic [5:0]  op, fn, eop, efn;
    logic [4:0]  rs, rt, rd, dest;
    logic [31:0] a, b, val, sext;
    int          kind;  // 0 writeback, 1 illegal, 2 nop
    int          w;
    op = ins[31:26]; fn = ins[5:0];
    rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11];
    sext = {{16{ins[15]}}, ins[15:0]};
    eop = 6'h00; efn = 6'h00; a = 0; b = 0; dest = 0; kind = 1;
    if (op == 6'h00) begin
      a = m_rf[rs]; b = m_rf[rt]; dest = rd; efn = fn;
      if (fn == 6'h00) kind = 2;
      else if (fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h18, 6'h1A}) kind = 0;
    end else if (op == 6'h08) begin
      a = m_rf[rs]; b = sext; dest = rt; efn = 6'h20; kind = 0;
    end else if (op == 6'h0F) begin
      eop = 6'h0F; b = {16'h0, ins[15:0]}; dest = rt; kind = 0;
    end
    val = alu_fn(eop, efn, a, b);

    instr = ins;
    instr_valid = 1'b1;
    dbg_addr = dest;
    w = 0;
    while (!instr_ready && w < 10) begin
      @(negedge clk);
      w++;
    end
    if (!instr_ready) begin
      chk("ready_timeout", 32'(instr_ready), 32'd1);
      return;
    end
    if (back_to_back) chk("ready_every_3rd", w, 0);

    @(negedge clk);  // ISSUE
    chk("issue_ready", 32'(instr_ready), 0);
    chk("issue_illegal", 32'(illegal), 32'(kind == 1));
    chk("issue_wb_valid", 32'(wb_valid), 0);
    if (kind == 0) begin
      chk("issue_opcode", 32'(alu_opcode), 32'(eop));
      chk("issue_funct", 32'(alu_funct), 32'(efn));
      chk("issue_A", alu_A, a);
      chk("issue_B", alu_B, b);
    end

    @(negedge clk);  // WB
    chk("wb_ready", 32'(instr_ready), 0);
    chk("wb_illegal", 32'(illegal), 0);
    chk("wb_valid", 32'(wb_valid), 32'(kind == 0));
    if (kind == 0) begin
      chk("wb_reg", 32'(wb_reg), 32'(dest));
      chk("wb_data", wb_data, val);
      chk("dbg_prewrite", dbg_data, m_rf[dest]);
      chk("alu_A_hold", alu_A, a);
      if (dest != 0) m_rf[dest] = val;
      m_zero = (val == 0);
    end

    @(negedge clk);  // back in IDLE
    chk("idle_ready", 32'(instr_ready), 1);
    chk("idle_wb_valid", 32'(wb_valid), 0);
    chk("idle_illegal", 32'(illegal), 0);
    chk("zero_flag", 32'(zero_flag), 32'(m_zero));
    chk("dbg_postwrite", dbg_data, m_rf[dest]);
  endtask

  task automatic check_all_regs(input string tag);
    for (int r = 0; r < 32; r++) begin
      dbg_addr = 5'(r);
      #1;
      chk(tag, dbg_data, m_rf[r]);
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0] functs [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h18, 6'h1A};
    logic [4:0] rs, rt, rd;
    logic [5:0] op;
    rs = 5'($urandom_range(0, 7));
    rt = 5'($urandom_range(0, 7));
    rd = 5'($urandom_range(0, 7));
    case ($urandom_range(0, 9))
      0, 1, 2, 3: return {6'h00, rs, rt, rd, 5'h0, functs[$urandom_range(0, 5)]};
      4, 5:       return {6'h08, rs, rt, 16'($urandom)};
      6:          return {6'h0F, 5'h0, rt, 16'($urandom)};
      7: begin
        do op = 6'($urandom); while (op inside {6'h00, 6'h08, 6'h0F});
        return {op, 26'($urandom)};
      end
      8:          return {6'h00, rs, rt, rd, 5'h0, 6'h3F};
      default:    return 32'h0000_0000;
    endcase
  endfunction

  initial begin
    for (int r = 0; r < 32; r++) m_rf[r] = 32'h0;
    m_zero = 1'b0;
    rst = 1'b1; instr_valid = 1'b0; instr = 32'h0; dbg_addr = 5'd0;
    repeat (3) @(negedge clk);
    chk("rst_opcode", 32'(alu_opcode), 0);
    chk("rst_funct", 32'(alu_funct), 0);
    chk("rst_A", alu_A, 0);
    chk("rst_B", alu_B, 0);
    chk("rst_wb_valid", 32'(wb_valid), 0);
    chk("rst_wb_reg", 32'(wb_reg), 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_zero_flag", 32'(zero_flag), 0);
    chk("rst_illegal", 32'(illegal), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_release_ready", 32'(instr_ready), 1);

    // Directed sequence, valid held high throughout.
    issue(32'h2001_000A, 1'b0);
    issue(32'h2002_000A, 1'b1);
    issue(32'h0022_1820, 1'b1);
    issue(32'h0022_2022, 1'b1);
    chk("sub_zero_flag", 32'(zero_flag), 1);
    issue(32'h3C05_0001, 1'b1);
    chk("lui_value", m_rf[5], 32'h0001_0000);
    issue(32'h2000_0005, 1'b1);
    issue(32'hFC00_0000, 1'b1);
    issue(32'h0022_183F, 1'b1);
    issue(32'h0000_0000, 1'b1);
    instr_valid = 1'b0;
    check_all_regs("rf_after_directed");

    // Random back-to-back traffic.
    for (int k = 0; k < 60; k++) issue(rand_instr(), k != 0);
    instr_valid = 1'b0;
    check_all_regs("rf_after_random");

    // Reset while an ADD is in ISSUE.
    instr = 32'h0022_1820;
    instr_valid = 1'b1;
    @(negedge clk);  // ISSUE
    chk("pre_reset_issue", 32'(instr_ready), 0);
    rst = 1'b1;
    instr_valid = 1'b0;
    @(negedge clk);
    chk("mid_reset_wb_valid", 32'(wb_valid), 0);
    rst = 1'b0;
    for (int r = 0; r < 32; r++) m_rf[r] = 32'h0;
    m_zero = 1'b0;
    @(negedge clk);
    chk("post_reset_ready", 32'(instr_ready), 1);
    chk("post_reset_wb_valid", 32'(wb_valid), 0);
    chk("post_reset_zero_flag", 32'(zero_flag), 0);
    check_all_regs("rf_after_reset");
    issue(32'h2003_0007, 1'b0);
    instr_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
